// File: rtl/spi_target.sv
// spi_target: single-lane SPI responder. Oversamples SCK/CSB/SD in the clk_i
// domain, deserialises MSB-first bytes into a 1-entry RX holding register and
// serialises bytes from a ready/valid TX stream. All four CPOL/CPHA modes.
module spi_target #(
    parameter int         SyncStages = 2,
    parameter logic [7:0] FillByte   = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cfg_cpol_i,
    input  logic       cfg_cpha_i,
    input  logic       spi_sck_i,
    input  logic       spi_csb_i,
    input  logic       spi_sd_i,
    output logic       spi_sd_o,
    output logic       spi_sd_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       rx_overflow_o,
    output logic       tx_underflow_o,
    output logic       busy_o
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SyncStages-1:0] r_sck_sync, r_csb_sync, r_sd_sync;
    logic                  r_sck_prev, r_csb_prev;

    state_t     r_state;
    logic       r_busy, r_sd_en;
    logic [2:0] r_bit_cnt;
    logic       r_bnd_pend;   // cpha=0: 8th sample seen, next shift edge loads
    logic [7:0] r_tx_shift, r_rx_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid, r_rx_ovf;

    logic       w_sck, w_csb, w_sd;
    logic       w_csb_fall, w_csb_rise, w_lead, w_trail;
    logic       w_active, w_do_sample, w_do_shift, w_boundary;
    logic       w_load, w_rx_done;
    logic [7:0] w_rx_byte, w_tx_next;

    // Input synchronisers plus one edge-detect flop. CSB resets low so that a
    // reset taken with CSB already low never looks like a fresh falling edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck_sync <= '0;
            r_csb_sync <= '0;
            r_sd_sync  <= '0;
            r_sck_prev <= 1'b0;
            r_csb_prev <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SyncStages-2:0], spi_sck_i};
            r_csb_sync <= {r_csb_sync[SyncStages-2:0], spi_csb_i};
            r_sd_sync  <= {r_sd_sync[SyncStages-2:0],  spi_sd_i};
            r_sck_prev <= r_sck_sync[SyncStages-1];
            r_csb_prev <= r_csb_sync[SyncStages-1];
        end
    end

    assign w_sck = r_sck_sync[SyncStages-1];
    assign w_csb = r_csb_sync[SyncStages-1];
    assign w_sd  = r_sd_sync[SyncStages-1];

    assign w_csb_fall = r_csb_prev & ~w_csb;
    assign w_csb_rise = ~r_csb_prev & w_csb;
    // Leading edge leaves the idle level, trailing edge returns to it.
    assign w_lead  = cfg_cpol_i ? (r_sck_prev & ~w_sck) : (~r_sck_prev & w_sck);
    assign w_trail = cfg_cpol_i ? (~r_sck_prev & w_sck) : (r_sck_prev & ~w_sck);

    // CSB rising wins over any SCK edge seen in the same cycle.
    assign w_active    = (r_state == ACTIVE) & ~w_csb_rise;
    assign w_do_sample = w_active & (cfg_cpha_i ? w_trail : w_lead);
    assign w_do_shift  = w_active & (cfg_cpha_i ? w_lead : w_trail);
    assign w_boundary  = cfg_cpha_i ? (r_bit_cnt == 3'd0) : r_bnd_pend;

    assign w_load = ~rst_i &
                    (((r_state == IDLE) & w_csb_fall & ~cfg_cpha_i) |
                     (w_do_shift & w_boundary));
    assign w_tx_next = tx_valid_i ? tx_data_i : FillByte;

    assign w_rx_byte = {r_rx_shift[6:0], w_sd};
    assign w_rx_done = w_do_sample & (r_bit_cnt == 3'd7);

    // Transfer FSM: bit counter, shift registers and pad enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_sd_en    <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_bnd_pend <= 1'b0;
            r_tx_shift <= 8'h00;
            r_rx_shift <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_csb_fall) begin
                        r_state    <= ACTIVE;
                        r_busy     <= 1'b1;
                        r_sd_en    <= 1'b1;
                        r_bit_cnt  <= 3'd0;
                        r_bnd_pend <= 1'b0;
                        r_rx_shift <= 8'h00;
                    end
                    if (w_load)
                        r_tx_shift <= w_tx_next;
                end
                ACTIVE: begin
                    if (w_csb_rise) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_sd_en    <= 1'b0;
                        r_bit_cnt  <= 3'd0;
                        r_bnd_pend <= 1'b0;
                        r_rx_shift <= 8'h00;
                    end else begin
                        if (w_do_sample) begin
                            r_rx_shift <= w_rx_byte;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (w_rx_done && !cfg_cpha_i)
                                r_bnd_pend <= 1'b1;
                        end
                        if (w_load) begin
                            r_tx_shift <= w_tx_next;
                            r_bnd_pend <= 1'b0;
                        end else if (w_do_shift) begin
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RX holding register: keep the old byte on overflow, but a completion
    // coinciding with an accepting handshake simply replaces it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_ovf   <= 1'b0;
        end else begin
            r_rx_ovf <= 1'b0;
            if (w_rx_done) begin
                if (r_rx_valid && !rx_ready_i) begin
                    r_rx_ovf <= 1'b1;
                end else begin
                    r_rx_data  <= w_rx_byte;
                    r_rx_valid <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign spi_sd_o       = r_sd_en & r_tx_shift[7];
    assign spi_sd_en_o    = r_sd_en;
    assign busy_o         = r_busy;
    assign rx_data_o      = r_rx_data;
    assign rx_valid_o     = r_rx_valid;
    assign rx_overflow_o  = r_rx_ovf;
    assign tx_ready_o     = w_load;
    assign tx_underflow_o = w_load & ~tx_valid_i;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bit-banged SPI initiator, negedge monitor.
module tb_spi_target;

    localparam int H = 8;   // SCK half period in clk_i cycles (SCK = clk/16)

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cfg_cpol_i = 1'b0, cfg_cpha_i = 1'b0;
    logic       spi_sck_i = 1'b0, spi_csb_i = 1'b1, spi_sd_i = 1'b0;
    logic       spi_sd_o, spi_sd_en_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i = 1'b1;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o, rx_overflow_o, tx_underflow_o, busy_o;

    int vec = 0, err = 0;
    int n_txr = 0, n_unf = 0, n_ovf = 0;
    int txr_snap = 0;
    logic [7:0] rx_log[$];

    spi_target #(.SyncStages(2), .FillByte(8'hFF)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_cpol_i(cfg_cpol_i), .cfg_cpha_i(cfg_cpha_i),
        .spi_sck_i(spi_sck_i), .spi_csb_i(spi_csb_i), .spi_sd_i(spi_sd_i),
        .spi_sd_o(spi_sd_o), .spi_sd_en_o(spi_sd_en_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_overflow_o(rx_overflow_o), .tx_underflow_o(tx_underflow_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: log accepted RX bytes and count high cycles of the strobes.
    always @(negedge clk_i) begin
        if (rx_valid_o && rx_ready_i) rx_log.push_back(rx_data_o);
        if (tx_ready_o)     n_txr++;
        if (tx_underflow_o) n_unf++;
        if (rx_overflow_o)  n_ovf++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        cfg_cpol_i = cpol;
        cfg_cpha_i = cpha;
        spi_sck_i  = cpol;
        wait_clk(H);
    endtask

    task automatic csb_low();
        spi_csb_i = 1'b0;
        wait_clk(H);
    endtask

    task automatic csb_high();
        wait_clk(H);
        spi_csb_i = 1'b1;
        wait_clk(H);
    endtask

    // Initiator: shifts the top nbits of mosi, captures MISO on each sample edge.
    task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cfg_cpha_i) begin
                spi_sd_i = mosi[i];
                wait_clk(H);
                miso[i] = spi_sd_o;
                if (i == 0) txr_snap = n_txr;
                spi_sck_i = ~cfg_cpol_i;
                wait_clk(H);
                spi_sck_i = cfg_cpol_i;
            end else begin
                spi_sck_i = ~cfg_cpol_i;
                spi_sd_i  = mosi[i];
                wait_clk(H);
                miso[i] = spi_sd_o;
                spi_sck_i = cfg_cpol_i;
                wait_clk(H);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        vec++;
        if ({spi_sd_o, spi_sd_en_o, rx_data_o, rx_valid_o, tx_ready_o,
             rx_overflow_o, tx_underflow_o, busy_o} !== 15'h0) begin
            err++;
            $display("FAIL %s outputs: got sd=%b en=%b rx=%h v=%b trdy=%b ovf=%b unf=%b busy=%b, expected all 0",
                     tag, spi_sd_o, spi_sd_en_o, rx_data_o, rx_valid_o, tx_ready_o,
                     rx_overflow_o, tx_underflow_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        wait_clk(3);
        check_all_zero("reset");
        rst_i = 1'b0;
        wait_clk(4);
        vec++;
        if (busy_o !== 1'b0) begin err++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_mode0();
        int rb = rx_log.size(), tb0 = n_txr, ub = n_unf;
        logic [7:0] m;
        set_mode(1'b0, 1'b0);
        tx_data_i = 8'h3C; tx_valid_i = 1'b1;
        csb_low();
        vec++;
        if ({busy_o, spi_sd_en_o} !== 2'b11) begin err++; $display("FAIL m0_busy_en: got %b expected 11", {busy_o, spi_sd_en_o}); end
        spi_bits(8'hA5, 8, m);
        csb_high();
        vec++;
        if (rx_log.size() - rb !== 1) begin err++; $display("FAIL m0_rx_count: got %0d expected 1", rx_log.size() - rb); end
        else begin
            vec++;
            if (rx_log[rb] !== 8'hA5) begin err++; $display("FAIL m0_rx_data: got %h expected a5", rx_log[rb]); end
        end
        vec++;
        if (m !== 8'h3C) begin err++; $display("FAIL m0_miso: got %h expected 3c", m); end
        // One load for the byte itself; the trailing edge after the 8th
        // sample is the next byte boundary and loads again.
        vec++;
        if (txr_snap - tb0 !== 1) begin err++; $display("FAIL m0_tx_ready_byte: got %0d expected 1", txr_snap - tb0); end
        vec++;
        if (n_txr - tb0 !== 2) begin err++; $display("FAIL m0_tx_ready_total: got %0d expected 2", n_txr - tb0); end
        vec++;
        if (n_unf - ub !== 0) begin err++; $display("FAIL m0_underflow: got %0d expected 0", n_unf - ub); end
        vec++;
        if ({busy_o, spi_sd_en_o} !== 2'b00) begin err++; $display("FAIL m0_idle: got %b expected 00", {busy_o, spi_sd_en_o}); end
    endtask

    task automatic test_back_to_back();
        int rb = rx_log.size(), tb0 = n_txr, ub = n_unf, ob = n_ovf;
        logic [7:0] m0, m1;
        set_mode(1'b1, 1'b1);
        tx_valid_i = 1'b1;
        csb_low();
        tx_data_i = 8'h55;
        spi_bits(8'h12, 8, m0);
        tx_data_i = 8'hAA;
        spi_bits(8'h34, 8, m1);
        csb_high();
        vec++;
        if (rx_log.size() - rb !== 2) begin err++; $display("FAIL b2b_rx_count: got %0d expected 2", rx_log.size() - rb); end
        else begin
            vec++;
            if ({rx_log[rb], rx_log[rb+1]} !== 16'h1234) begin
                err++; $display("FAIL b2b_rx_data: got %h %h expected 12 34", rx_log[rb], rx_log[rb+1]);
            end
        end
        vec++;
        if ({m0, m1} !== 16'h55AA) begin err++; $display("FAIL b2b_miso: got %h %h expected 55 aa", m0, m1); end
        vec++;
        if (n_txr - tb0 !== 2) begin err++; $display("FAIL b2b_tx_ready: got %0d expected 2", n_txr - tb0); end
        vec++;
        if ((n_unf - ub) + (n_ovf - ob) !== 0) begin
            err++; $display("FAIL b2b_errors: got unf=%0d ovf=%0d expected 0 0", n_unf - ub, n_ovf - ob);
        end
    endtask

    task automatic test_overflow();
        int rb = rx_log.size(), ob = n_ovf;
        logic [7:0] m;
        set_mode(1'b0, 1'b0);
        rx_ready_i = 1'b0; tx_valid_i = 1'b1; tx_data_i = 8'h00;
        csb_low();
        spi_bits(8'h01, 8, m);
        spi_bits(8'h02, 8, m);
        csb_high();
        vec++;
        if ({rx_valid_o, rx_data_o} !== 9'h101) begin
            err++; $display("FAIL ovf_hold: got v=%b data=%h expected v=1 data=01", rx_valid_o, rx_data_o);
        end
        vec++;
        if (n_ovf - ob !== 1) begin err++; $display("FAIL ovf_pulse: got %0d expected 1", n_ovf - ob); end
        rx_ready_i = 1'b1;
        wait_clk(3);
        vec++;
        if (rx_log.size() - rb !== 1) begin err++; $display("FAIL ovf_drain_count: got %0d expected 1", rx_log.size() - rb); end
        else begin
            vec++;
            if (rx_log[rb] !== 8'h01) begin err++; $display("FAIL ovf_drain_data: got %h expected 01", rx_log[rb]); end
        end
        vec++;
        if (rx_valid_o !== 1'b0) begin err++; $display("FAIL ovf_valid_clear: got %b expected 0", rx_valid_o); end
    endtask

    task automatic test_underflow();
        int rb = rx_log.size(), tb0 = n_txr, ub = n_unf;
        logic [7:0] m;
        set_mode(1'b0, 1'b1);
        tx_valid_i = 1'b0; tx_data_i = 8'h00;
        csb_low();
        spi_bits(8'h6E, 8, m);
        csb_high();
        vec++;
        if (m !== 8'hFF) begin err++; $display("FAIL unf_miso: got %h expected ff", m); end
        vec++;
        if (n_unf - ub !== 1) begin err++; $display("FAIL unf_pulse: got %0d expected 1", n_unf - ub); end
        vec++;
        if (n_txr - tb0 !== 1) begin err++; $display("FAIL unf_tx_ready: got %0d expected 1", n_txr - tb0); end
        vec++;
        if (rx_log.size() - rb !== 1) begin err++; $display("FAIL unf_rx_count: got %0d expected 1", rx_log.size() - rb); end
        else begin
            vec++;
            if (rx_log[rb] !== 8'h6E) begin err++; $display("FAIL unf_rx_data: got %h expected 6e", rx_log[rb]); end
        end
    endtask

    task automatic test_csb_abort();
        int rb = rx_log.size();
        logic [7:0] m;
        set_mode(1'b0, 1'b0);
        tx_valid_i = 1'b1; tx_data_i = 8'h00;
        csb_low();
        spi_bits(8'hF0, 5, m);
        csb_high();
        vec++;
        if ({busy_o, spi_sd_en_o} !== 2'b00) begin err++; $display("FAIL abort_idle: got %b expected 00", {busy_o, spi_sd_en_o}); end
        vec++;
        if (rx_log.size() - rb !== 0) begin err++; $display("FAIL abort_partial: got %0d bytes expected 0", rx_log.size() - rb); end
        csb_low();
        spi_bits(8'h81, 8, m);
        csb_high();
        vec++;
        if (rx_log.size() - rb !== 1) begin err++; $display("FAIL abort_rx_count: got %0d expected 1", rx_log.size() - rb); end
        else begin
            vec++;
            if (rx_log[rb] !== 8'h81) begin err++; $display("FAIL abort_rx_data: got %h expected 81", rx_log[rb]); end
        end
    endtask

    task automatic test_reset_midbyte();
        int rb = rx_log.size();
        logic [7:0] m;
        set_mode(1'b0, 1'b0);
        tx_valid_i = 1'b1; tx_data_i = 8'hC3;
        csb_low();
        spi_bits(8'hC3, 4, m);
        rst_i = 1'b1;
        wait_clk(1);
        check_all_zero("rst_mid");
        rst_i = 1'b0;
        spi_bits(8'h3C, 8, m);
        vec++;
        if (busy_o !== 1'b0) begin err++; $display("FAIL rst_mid_stay_idle: got busy=%b expected 0", busy_o); end
        csb_high();
        vec++;
        if (rx_log.size() - rb !== 0) begin err++; $display("FAIL rst_mid_no_rx: got %0d bytes expected 0", rx_log.size() - rb); end
        csb_low();
        spi_bits(8'h5A, 8, m);
        csb_high();
        vec++;
        if (rx_log.size() - rb !== 1) begin err++; $display("FAIL rst_mid_rx_count: got %0d expected 1", rx_log.size() - rb); end
        else begin
            vec++;
            if (rx_log[rb] !== 8'h5A) begin err++; $display("FAIL rst_mid_rx_data: got %h expected 5a", rx_log[rb]); end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_csb_abort();
        test_reset_midbyte();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
